msg_schedule: RTL and testbench

MSG_SCHEDULE -- requirements
Module: msg_schedule

---
 rtl/sha_pkg.sv | 36 +++
 rtl/sigma_func.sv | 19 +
 rtl/msg_schedule.sv | 116 +++++++++++
 tb/tb_msg_schedule.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-2 message schedule expander:
// FSM states, sigma rotate/shift amounts and default round counts.
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

  localparam int unsigned ROUNDS_256 = 32'd64;
  localparam int unsigned ROUNDS_512 = 32'd80;

  // SHA-256 small sigmas
  localparam int unsigned S0_R1_32 = 32'd7;
  localparam int unsigned S0_R2_32 = 32'd18;
  localparam int unsigned S0_SH_32 = 32'd3;
  localparam int unsigned S1_R1_32 = 32'd17;
  localparam int unsigned S1_R2_32 = 32'd19;
  localparam int unsigned S1_SH_32 = 32'd10;

  // SHA-512 small sigmas
  localparam int unsigned S0_R1_64 = 32'd1;
  localparam int unsigned S0_R2_64 = 32'd8;
  localparam int unsigned S0_SH_64 = 32'd7;
  localparam int unsigned S1_R1_64 = 32'd19;
  localparam int unsigned S1_R2_64 = 32'd61;
  localparam int unsigned S1_SH_64 = 32'd6;

  function automatic int unsigned pick_amt(input int unsigned width,
                                           input int unsigned amt32,
                                           input int unsigned amt64);
    return (width == 32'd64) ? amt64 : amt32;
  endfunction

endpackage

// File: rtl/sigma_func.sv
// Small sigma: rotr(R1) ^ rotr(R2) ^ shr(S), purely combinational.
module sigma_func #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned R1    = 7,
  parameter int unsigned R2    = 18,
  parameter int unsigned S     = 3
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] rot1_s;
  logic [WIDTH-1:0] rot2_s;

  assign rot1_s = (x >> R1) | (x << (WIDTH - R1));
  assign rot2_s = (x >> R2) | (x << (WIDTH - R2));
  assign y      = rot1_s ^ rot2_s ^ (x >> S);

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: passes the 16 message words through, then expands
// W[16..ROUNDS-1] from a 16-word sliding window, one word per accepted transfer.
module msg_schedule
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROUNDS = ROUNDS_256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [6:0]       out_index,
  output logic             busy,
  output logic             done
);

  localparam int unsigned S0_R1 = pick_amt(WIDTH, S0_R1_32, S0_R1_64);
  localparam int unsigned S0_R2 = pick_amt(WIDTH, S0_R2_32, S0_R2_64);
  localparam int unsigned S0_SH = pick_amt(WIDTH, S0_SH_32, S0_SH_64);
  localparam int unsigned S1_R1 = pick_amt(WIDTH, S1_R1_32, S1_R1_64);
  localparam int unsigned S1_R2 = pick_amt(WIDTH, S1_R2_32, S1_R2_64);
  localparam int unsigned S1_SH = pick_amt(WIDTH, S1_SH_32, S1_SH_64);
  localparam logic [6:0]  LAST_T = 7'(ROUNDS - 32'd1);

  state_t           state_r;
  state_t           state_next_s;
  logic [6:0]       t_r;
  logic [WIDTH-1:0] window_r [16];
  logic [WIDTH-1:0] s0_s;
  logic [WIDTH-1:0] s1_s;
  logic [WIDTH-1:0] sum_s;
  logic             xfer_s;

  sigma_func #(.WIDTH(WIDTH), .R1(S0_R1), .R2(S0_R2), .S(S0_SH)) u_s0 (
    .x (window_r[1]),
    .y (s0_s)
  );

  sigma_func #(.WIDTH(WIDTH), .R1(S1_R1), .R2(S1_R2), .S(S1_SH)) u_s1 (
    .x (window_r[14]),
    .y (s1_s)
  );

  // window[15] is W[t-1], so W[t-2], W[t-7], W[t-15], W[t-16] sit at 14, 9, 1, 0
  assign sum_s     = s1_s + window_r[9] + s0_s + window_r[0];
  assign xfer_s    = out_valid & out_ready;
  assign out_index = t_r;

  // Next-state and stream handshake decode
  always_comb begin
    state_next_s = state_r;
    out_valid    = 1'b0;
    out_data     = '0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = LOAD;
        else       state_next_s = IDLE;
      end
      LOAD: begin
        busy      = 1'b1;
        out_valid = in_valid;
        in_ready  = out_ready;
        if (in_valid) out_data = in_data;
        else          out_data = '0;
        if (in_valid && out_ready && (t_r == 7'd15)) state_next_s = EXPAND;
        else                                         state_next_s = LOAD;
      end
      EXPAND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sum_s;
        if (out_ready && (t_r == LAST_T)) begin
          state_next_s = IDLE;
          done         = 1'b1;
        end else begin
          state_next_s = EXPAND;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State and word counter; t wraps to 0 on the last word so the next block starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      t_r     <= 7'd0;
    end else begin
      state_r <= state_next_s;
      if (xfer_s) begin
        if ((state_r == EXPAND) && (t_r == LAST_T)) t_r <= 7'd0;
        else                                        t_r <= t_r + 7'd1;
      end
    end
  end

  // Sliding window: every accepted word shifts in at the newest end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) window_r[i] <= '0;
    end else if (xfer_s) begin
      for (int i = 0; i < 15; i++) window_r[i] <= window_r[i+1];
      window_r[15] <= out_data;
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: SHA-256 and SHA-512 instances, expected
// schedules from a direct recurrence model, checked by a decoupled monitor.
module tb_msg_schedule;

  typedef struct {
    logic [63:0] d;
    int          i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start, in_valid, out_ready;
  logic [1:0]  in_ready_v, out_valid_v, busy_v, done_v;
  logic [63:0] in_data [2];
  logic [31:0] od32;
  logic [63:0] od64;
  logic [6:0]  oidx [2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0, checks = 0;
  int   done_cnt [2];
  int   exp_done [2];

  logic [63:0] abc32 [16];
  logic [63:0] abc64 [16];
  logic [63:0] rnd   [16];

  always #5 clk = ~clk;

  msg_schedule #(.WIDTH(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0][31:0]), .in_ready(in_ready_v[0]),
    .out_valid(out_valid_v[0]), .out_data(od32), .out_ready(out_ready[0]),
    .out_index(oidx[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  msg_schedule #(.WIDTH(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready_v[1]),
    .out_valid(out_valid_v[1]), .out_data(od64), .out_ready(out_ready[1]),
    .out_index(oidx[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  function automatic logic [63:0] od_of(input int s);
    return (s == 1) ? od64 : {32'd0, od32};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int wd);
    logic [63:0] m;
    m = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (wd - n))) & m;
  endfunction

  // Reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  function automatic void sched(input logic [63:0] m [16], input bit w64, output logic [63:0] w [80]);
    logic [63:0] mask, a, b, s0, s1;
    int wd;
    wd   = w64 ? 64 : 32;
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        w[t] = m[t] & mask;
      end else begin
        a = w[t-15];
        b = w[t-2];
        s0 = w64 ? (rotr(a, 1, wd) ^ rotr(a, 8, wd) ^ (a >> 7))
                 : (rotr(a, 7, wd) ^ rotr(a, 18, wd) ^ (a >> 3));
        s1 = w64 ? (rotr(b, 19, wd) ^ rotr(b, 61, wd) ^ (b >> 6))
                 : (rotr(b, 17, wd) ^ rotr(b, 19, wd) ^ (b >> 10));
        w[t] = (s1 + w[t-7] + s0 + w[t-16]) & mask;
      end
    end
  endfunction

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    exp_t e;
    int   rl;
    bit   empty;
    for (int s = 0; s < 2; s++) begin
      rl = (s == 1) ? 80 : 64;
      if (out_valid_v[s] && out_ready[s]) begin
        empty = (s == 1) ? (q1.size() == 0) : (q0.size() == 0);
        if (empty) begin
          chk(1'b0, "unexpected_output", {57'd0, oidx[s]}, 64'd0);
        end else begin
          if (s == 1) e = q1.pop_front();
          else        e = q0.pop_front();
          chk(od_of(s) == e.d, "out_data", od_of(s), e.d);
          chk(oidx[s] == 7'(e.i), "out_index", {57'd0, oidx[s]}, 64'(e.i));
          chk(done_v[s] == (e.i == rl - 1), "done_on_last", {63'd0, done_v[s]}, 64'(e.i == rl - 1));
        end
      end else begin
        if (done_v[s]) chk(1'b0, "spurious_done", 64'd1, 64'd0);
        chk(out_valid_v[s] || (od_of(s) == 64'd0), "idle_data_zero", od_of(s), 64'd0);
      end
      if (done_v[s]) done_cnt[s]++;
    end
  end

  // mode: 0 ready, 1 random handshakes, 2 start pulse in EXPAND, 3 reset at t=30, 4 stall at t=20
  task automatic run(input int sel, input logic [63:0] msg [16], input int mode, input int gap);
    logic [63:0] w [80];
    logic [63:0] hold_d;
    logic [6:0]  hold_i;
    int rounds, n, k, cyc, stalls, d0;
    bit hs_in, hs_out, stall_now;
    exp_t e;
    rounds = (sel == 1) ? 80 : 64;
    sched(msg, sel == 1, w);
    for (int t = 0; t < rounds; t++) begin
      if (mode != 3 || t < 30) begin
        e.d = w[t];
        e.i = t;
        if (sel == 1) q1.push_back(e);
        else          q0.push_back(e);
      end
    end
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    d0 = done_cnt[sel];
    start[sel] = 1'b1; in_valid[sel] = 1'b1; in_data[sel] = msg[0]; out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    chk(busy_v[sel] == 1'b1, "start_accepted", {63'd0, busy_v[sel]}, 64'd1);
    n = 0; k = 0; cyc = 0; stalls = 0;
    hold_d = 64'd0; hold_i = 7'd0;
    while (n < rounds && cyc < 3000) begin
      if (mode == 3 && n == 30) begin
        rst_n = 1'b0;
        #1;
        chk(out_valid_v[sel] == 1'b0, "rst_out_valid", {63'd0, out_valid_v[sel]}, 64'd0);
        chk(od_of(sel) == 64'd0, "rst_out_data", od_of(sel), 64'd0);
        chk(oidx[sel] == 7'd0, "rst_out_index", {57'd0, oidx[sel]}, 64'd0);
        chk(in_ready_v[sel] == 1'b0, "rst_in_ready", {63'd0, in_ready_v[sel]}, 64'd0);
        chk(busy_v[sel] == 1'b0, "rst_busy", {63'd0, busy_v[sel]}, 64'd0);
        chk(done_v[sel] == 1'b0, "rst_done", {63'd0, done_v[sel]}, 64'd0);
        in_valid[sel] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk(done_cnt[sel] == d0, "no_done_after_reset", 64'(done_cnt[sel] - d0), 64'd0);
        return;
      end
      stall_now      = (mode == 4) && (n == 20) && (stalls < 5);
      in_valid[sel]  = (k < 16 && mode != 1) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data[sel]   = (k < 16) ? msg[k] : {$urandom, $urandom};
      out_ready[sel] = (mode == 1) ? ($urandom_range(0, 3) != 0) : !stall_now;
      start[sel]     = (mode == 2) && (n == 40);
      @(negedge clk);
      hs_out = out_valid_v[sel] && out_ready[sel];
      hs_in  = in_valid[sel] && in_ready_v[sel];
      if (stall_now) begin
        if (stalls == 0) begin
          hold_d = od_of(sel);
          hold_i = oidx[sel];
        end else begin
          chk(od_of(sel) == hold_d, "stall_data_hold", od_of(sel), hold_d);
          chk(oidx[sel] == hold_i, "stall_index_hold", {57'd0, oidx[sel]}, {57'd0, hold_i});
        end
        stalls++;
      end
      @(posedge clk); #1;
      start[sel] = 1'b0;
      if (hs_in)  k++;
      if (hs_out) n++;
      cyc++;
    end
    chk(cyc < 3000, "block_timeout", 64'(cyc), 64'd3000);
    chk(done_cnt[sel] - d0 == 1, "done_once", 64'(done_cnt[sel] - d0), 64'd1);
    exp_done[sel]++;
    in_valid[sel] = 1'b0;
  endtask

  task automatic fill_rand(output logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
  endtask

  initial begin
    start = 2'b00; in_valid = 2'b00; out_ready = 2'b00;
    in_data[0] = 64'd0; in_data[1] = 64'd0;
    done_cnt[0] = 0; done_cnt[1] = 0; exp_done[0] = 0; exp_done[1] = 0;
    for (int i = 0; i < 16; i++) begin abc32[i] = 64'd0; abc64[i] = 64'd0; end
    abc32[0]  = 64'h0000_0000_6162_6380;
    abc32[15] = 64'h0000_0000_0000_0018;
    abc64[0]  = 64'h6162_6380_0000_0000;
    abc64[15] = 64'h0000_0000_0000_0018;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk(out_valid_v[s] == 1'b0, "reset_out_valid", {63'd0, out_valid_v[s]}, 64'd0);
      chk(od_of(s) == 64'd0, "reset_out_data", od_of(s), 64'd0);
      chk(oidx[s] == 7'd0, "reset_out_index", {57'd0, oidx[s]}, 64'd0);
      chk(busy_v[s] == 1'b0, "reset_busy", {63'd0, busy_v[s]}, 64'd0);
      chk(in_ready_v[s] == 1'b0, "reset_in_ready", {63'd0, in_ready_v[s]}, 64'd0);
      chk(done_v[s] == 1'b0, "reset_done", {63'd0, done_v[s]}, 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    run(0, abc32, 0, 1);
    fill_rand(rnd); run(0, rnd, 1, 2);
    fill_rand(rnd); run(0, rnd, 4, 1);
    fill_rand(rnd); run(0, rnd, 2, 1);
    run(0, abc32, 3, 1);
    run(0, abc32, 0, 1);
    fill_rand(rnd); run(0, rnd, 0, 0);
    fill_rand(rnd); run(0, rnd, 1, 0);
    run(1, abc64, 0, 1);
    fill_rand(rnd); run(1, rnd, 1, 0);
    fill_rand(rnd); run(1, rnd, 4, 2);

    repeat (3) @(posedge clk);
    #1;
    chk(q0.size() == 0, "q32_drained", 64'(q0.size()), 64'd0);
    chk(q1.size() == 0, "q64_drained", 64'(q1.size()), 64'd0);
    chk(done_cnt[0] == exp_done[0], "done_total_32", 64'(done_cnt[0]), 64'(exp_done[0]));
    chk(done_cnt[1] == exp_done[1], "done_total_64", 64'(done_cnt[1]), 64'(exp_done[1]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
